dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
Data-memory responder at the far end of the core's Writeback-stage memory interface; it serves the store and load requests issued by the pipeline control.
- Accepts one request at a time via a valid/ready handshake.
- Holds it for a fixed access latency, then performs the write or read.
- Returns a one-cycle response pulse carrying read data and an error flag.
- Drives busy, which the hazard logic uses to stall the pipeline.

Parameters:
DEPTH_WORDS, 1024, number of 32-bit words in the backing array (power of two, >= 4)
LATENCY, 2, cycles from request acceptance to rsp_valid (1..15)

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  synchronous, active-low reset (0 = reset)
req_valid  input  1  request present
req_ready  output  1  responder can accept a request this cycle
req_write  input  1  1 = store, 0 = load (driven from MemWriteW)
req_addr  input  32  byte address
req_wdata  input  32  store data
req_be  input  4  store byte enables; bit i covers bits [8i+7:8i]
rsp_valid  output  1  one-cycle response pulse
rsp_rdata  output  32  load data, valid with rsp_valid
rsp_err  output  1  request faulted, valid with rsp_valid
busy  output  1  request in flight (state != IDLE)

Behaviour:
- Reset values:
  - state = IDLE; rsp_valid, rsp_err, busy = 0; rsp_rdata = 0; counter = 0.
  - req_ready = 0 while reset = 0 and 1 afterwards.
  - Array contents are not cleared.
- States:
  - IDLE: req_ready = 1.
  - WAIT: counting down.
  - RESP: rsp_valid = 1 for exactly one cycle.
- Handshake:
  - A request is accepted when req_valid & req_ready.
  - On acceptance, latch write, addr, wdata and be.
  - Requestor inputs are ignored outside IDLE.
- Transitions:
  - IDLE -> WAIT on accept with counter = LATENCY-2 when LATENCY >= 2.
  - IDLE -> RESP directly when LATENCY = 1.
  - WAIT decrements the counter and moves to RESP when counter = 0.
  - RESP -> IDLE unconditionally. There is no response backpressure.
- Latency: rsp_valid is high exactly LATENCY cycles after the accept edge.
- Throughput: one request per LATENCY+1 cycles; a new request can be accepted in the cycle after RESP.
- Faults: rsp_err = 1 if the latched addr[1:0] != 0 (misaligned) or the word index addr[31:2] >= DEPTH_WORDS.
  - On fault: no write, rsp_rdata = 0.
- Store:
  - Committed on the clock edge that ends RESP; only bytes with be = 1 are written.
  - be = 0000 is legal: no change, rsp_err = 0.
  - rsp_rdata = 0 for stores.
- Load: rsp_rdata = the full word at the latched index, read combinationally in RESP. Byte enables are ignored.
- Ordering: a load accepted after a store response sees the stored data. Back-to-back accesses to the same word are coherent.
- Reset mid-operation: the in-flight request is discarded and no write occurs. This holds even if reset coincides with RESP, because reset has priority over the array write.
- Word index arithmetic: index = addr[2+log2(DEPTH_WORDS)-1:2] after the range check. Upper address bits are used only for the check, never truncated silently.

Optional Feature:
DMEM_BUSY_CNT_EN
- Defined:
  - Adds output busy_cnt[31:0], reset to 0.
  - Increments on every cycle busy = 1 and saturates at 0xFFFFFFFF.
- Undefined: no port and no counter logic. All other behaviour is identical.

Decomposition:
- Shared package dmem_pkg:
  - State enum dmem_state_t (IDLE, WAIT, RESP).
  - Constant BE_ALL = 4'b1111.
  - Function word_index computing the index and range check.
- Sub-module dmem_array:
  - Holds the DEPTH_WORDS x 32 storage.
  - Byte-enable synchronous write port (we, idx, wdata, be) and combinational read port (idx -> rdata).

Test Plan:
- LATENCY=2, after reset: store addr 0x10, wdata 0xDEADBEEF, be 1111 -> rsp_valid 2 cycles after accept, rsp_err 0. Then load 0x10 -> rsp_rdata 0xDEADBEEF.
- Partial store be 0010, wdata 0x0000AB00, over word 0xDEADBEEF at 0x10 -> subsequent load returns 0xDEADABEF.
- Load addr 0x13 -> rsp_err 1, rdata 0. Store addr 0x1000 with DEPTH_WORDS=1024 -> rsp_err 1, and word 0 is unchanged on readback.
- req_valid held high for 10 cycles, LATENCY=1 -> accepts every 2 cycles; busy high exactly on the cycles between accept and RESP.
- Store accepted, then reset = 0 in the RESP cycle -> no rsp_valid after reset and the target word keeps its old value; req_ready = 1 on the first cycle after reset = 1.
- With DMEM_BUSY_CNT_EN, LATENCY=3, three loads -> busy_cnt = 9; the count returns to 0 after reset.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_t;

  localparam logic [3:0] BE_ALL = 4'b1111;
  localparam int         CNT_W  = 4;

  typedef struct packed {
    logic        ok;
    logic [29:0] idx;
  } word_sel_t;

  // Full 30-bit word index plus alignment/range check; callers truncate only after ok is known.
  function automatic word_sel_t word_index(input logic [31:0] addr, input int unsigned depth_words);
    word_sel_t sel;
    sel.idx = addr[31:2];
    sel.ok  = (addr[1:0] == 2'b00) && ({2'b00, addr[31:2]} < depth_words);
    return sel;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word storage split into four byte lanes: byte-enabled synchronous write, combinational read.
module dmem_array #(
  parameter int DEPTH_WORDS = 1024,
  parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IDX_W-1:0] idx,
  input  logic [31:0]      wdata,
  input  logic [3:0]       be,
  output logic [31:0]      rdata
);

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [7:0] lane_mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
      if (we && be[gi]) begin
        lane_mem[idx] <= wdata[8*gi +: 8];
      end
    end

    assign rdata[8*gi +: 8] = lane_mem[idx];
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one request at a time, fixed latency, one-cycle response pulse.
// Optional DMEM_BUSY_CNT_EN adds a saturating count of busy cycles on busy_cnt.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy
`ifdef DMEM_BUSY_CNT_EN
  ,
  output logic [31:0] busy_cnt
`endif
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  dmem_state_t      state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             write_reg;
  logic             err_reg;
  logic [IDX_W-1:0] idx_reg;
  logic [31:0]      wdata_reg;
  logic [3:0]       be_reg;
  logic             busy_reg;

  word_sel_t   sel;
  logic        accept;
  logic        in_resp;
  logic        arr_we;
  logic [31:0] arr_rdata;

  assign sel    = word_index(req_addr, DEPTH_WORDS);
  assign accept = req_valid && req_ready;

  if (IDX_W < 30) begin : g_idx_unused
    logic unused_idx_bits;
    assign unused_idx_bits = ^sel.idx[29:IDX_W];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      write_reg <= 1'b0;
      err_reg   <= 1'b0;
      idx_reg   <= '0;
      wdata_reg <= '0;
      be_reg    <= '0;
      busy_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            write_reg <= req_write;
            err_reg   <= !sel.ok;
            idx_reg   <= sel.idx[IDX_W-1:0];
            wdata_reg <= req_wdata;
            be_reg    <= req_be;
            busy_reg  <= 1'b1;
            if (LATENCY == 1) begin
              state_reg <= RESP;
            end else begin
              state_reg <= WAIT;
              cnt_reg   <= CNT_W'(LATENCY - 2);
            end
          end
        end
        WAIT: begin
          if (cnt_reg == '0) begin
            state_reg <= RESP;
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end
        RESP: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign in_resp   = (state_reg == RESP);
  assign req_ready = reset && (state_reg == IDLE);
  assign rsp_valid = in_resp;
  assign rsp_err   = in_resp && err_reg;
  assign rsp_rdata = (in_resp && !write_reg && !err_reg) ? arr_rdata : 32'h0;
  assign busy      = busy_reg;

  // Reset wins over a store that would commit on the same edge.
  assign arr_we = in_resp && write_reg && !err_reg && reset;

  dmem_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .IDX_W      (IDX_W)
  ) u_array (
    .clk  (clk),
    .we   (arr_we),
    .idx  (idx_reg),
    .wdata(wdata_reg),
    .be   (be_reg),
    .rdata(arr_rdata)
  );

`ifdef DMEM_BUSY_CNT_EN
  logic [31:0] busy_cnt_reg;

  always_ff @(posedge clk) begin
    if (!reset) begin
      busy_cnt_reg <= '0;
    end else if (busy_reg && (busy_cnt_reg != 32'hFFFF_FFFF)) begin
      busy_cnt_reg <= busy_cnt_reg + 32'd1;
    end
  end

  assign busy_cnt = busy_cnt_reg;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: LATENCY=2 and LATENCY=1 instances (plus LATENCY=3 with DMEM_BUSY_CNT_EN) share stimulus.
module tb_dmem_responder;
  import dmem_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        req_valid;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;

  logic        req_ready2, rsp_valid2, rsp_err2, busy2;
  logic [31:0] rsp_rdata2;
  logic        req_ready1, rsp_valid1, rsp_err1, busy1;
  logic [31:0] rsp_rdata1;
`ifdef DMEM_BUSY_CNT_EN
  logic [31:0] busy_cnt2, busy_cnt1, busy_cnt3;
  logic        req_ready3, rsp_valid3, rsp_err3, busy3;
  logic [31:0] rsp_rdata3;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(2)) u_dut2 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready2),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid2), .rsp_rdata(rsp_rdata2), .rsp_err(rsp_err2), .busy(busy2)
`ifdef DMEM_BUSY_CNT_EN
    , .busy_cnt(busy_cnt2)
`endif
  );

  dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(1)) u_dut1 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready1),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid1), .rsp_rdata(rsp_rdata1), .rsp_err(rsp_err1), .busy(busy1)
`ifdef DMEM_BUSY_CNT_EN
    , .busy_cnt(busy_cnt1)
`endif
  );

`ifdef DMEM_BUSY_CNT_EN
  dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(3)) u_dut3 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready3),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid3), .rsp_rdata(rsp_rdata3), .rsp_err(rsp_err3), .busy(busy3),
    .busy_cnt(busy_cnt3)
  );
`endif

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset     = 1'b0;
    req_valid = 1'b0;
    cyc();
    cyc();
    reset = 1'b1;
    #1;
  endtask

  // One request on the LATENCY=2 instance; returns cycles from accept edge to rsp_valid.
  task automatic xact(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] be, output int lat, output logic [31:0] rdata,
                      output logic err);
    int guard;
    guard     = 0;
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wdata;
    req_be    = be;
    while (!req_ready2 && guard < 20) begin
      cyc();
      guard++;
    end
    cyc();
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid2 && lat < 20) begin
      cyc();
      lat++;
    end
    rdata = rsp_rdata2;
    err   = rsp_err2;
    $display("[TB] %s addr=%08h wdata=%08h be=%b -> lat=%0d rdata=%08h err=%0b",
             wr ? "ST" : "LD", addr, wdata, be, lat, rdata, err);
    cyc();
  endtask

  task automatic test_reset();
    reset     = 1'b0;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    req_be    = '0;
    cyc();
    cyc();
    n_tests++; if (req_ready2 !== 1'b0) begin n_fail++; $display("FAIL rst_ready: got %b want 0", req_ready2); end
    n_tests++; if (rsp_valid2 !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", rsp_valid2); end
    n_tests++; if (busy2 !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy2); end
    n_tests++; if (rsp_rdata2 !== 32'h0) begin n_fail++; $display("FAIL rst_rdata: got %08h want 0", rsp_rdata2); end
    n_tests++; if (rsp_err2 !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b want 0", rsp_err2); end
    reset = 1'b1;
    #1;
    n_tests++; if (req_ready2 !== 1'b1) begin n_fail++; $display("FAIL rst_ready_after: got %b want 1", req_ready2); end
    n_tests++; if (req_ready1 !== 1'b1) begin n_fail++; $display("FAIL rst_ready1_after: got %b want 1", req_ready1); end
  endtask

  task automatic test_store_load();
    int lat; logic [31:0] rd; logic err;
    xact(1'b1, 32'h10, 32'hDEADBEEF, BE_ALL, lat, rd, err);
    n_tests++; if (lat !== 2) begin n_fail++; $display("FAIL st_lat: got %0d want 2", lat); end
    n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL st_err: got %b want 0", err); end
    n_tests++; if (rd !== 32'h0) begin n_fail++; $display("FAIL st_rdata: got %08h want 0", rd); end
    xact(1'b0, 32'h10, 32'h0, 4'b0000, lat, rd, err);
    n_tests++; if (lat !== 2) begin n_fail++; $display("FAIL ld_lat: got %0d want 2", lat); end
    n_tests++; if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL ld_rdata: got %08h want DEADBEEF", rd); end
    n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL ld_err: got %b want 0", err); end
  endtask

  task automatic test_partial_store();
    int lat; logic [31:0] rd; logic err;
    xact(1'b1, 32'h10, 32'h0000AB00, 4'b0010, lat, rd, err);
    n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL part_err: got %b want 0", err); end
    xact(1'b0, 32'h10, 32'h0, 4'b0000, lat, rd, err);
    n_tests++; if (rd !== 32'hDEADABEF) begin n_fail++; $display("FAIL part_rdata: got %08h want DEADABEF", rd); end
  endtask

  task automatic test_faults();
    int lat; logic [31:0] rd; logic err;
    xact(1'b0, 32'h13, 32'h0, 4'b0000, lat, rd, err);
    n_tests++; if (err !== 1'b1) begin n_fail++; $display("FAIL misalign_err: got %b want 1", err); end
    n_tests++; if (rd !== 32'h0) begin n_fail++; $display("FAIL misalign_rdata: got %08h want 0", rd); end
    n_tests++; if (lat !== 2) begin n_fail++; $display("FAIL misalign_lat: got %0d want 2", lat); end
    xact(1'b1, 32'h0, 32'h11223344, BE_ALL, lat, rd, err);
    n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL w0_err: got %b want 0", err); end
    xact(1'b1, 32'h1000, 32'hAAAAAAAA, BE_ALL, lat, rd, err);
    n_tests++; if (err !== 1'b1) begin n_fail++; $display("FAIL range_err: got %b want 1", err); end
    xact(1'b1, 32'h8000_0000, 32'h55555555, BE_ALL, lat, rd, err);
    n_tests++; if (err !== 1'b1) begin n_fail++; $display("FAIL high_err: got %b want 1", err); end
    xact(1'b0, 32'h0, 32'h0, 4'b0000, lat, rd, err);
    n_tests++; if (rd !== 32'h11223344) begin n_fail++; $display("FAIL w0_keep: got %08h want 11223344", rd); end
    xact(1'b1, 32'hFFC, 32'h0BADF00D, BE_ALL, lat, rd, err);
    n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL last_err: got %b want 0", err); end
    xact(1'b0, 32'hFFC, 32'h0, 4'b0000, lat, rd, err);
    n_tests++; if (rd !== 32'h0BADF00D) begin n_fail++; $display("FAIL last_rdata: got %08h want 0BADF00D", rd); end
    xact(1'b1, 32'h12, 32'h77777777, BE_ALL, lat, rd, err);
    n_tests++; if (err !== 1'b1) begin n_fail++; $display("FAIL st_misalign_err: got %b want 1", err); end
    xact(1'b1, 32'h10, 32'hFFFFFFFF, 4'b0000, lat, rd, err);
    n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL be0_err: got %b want 0", err); end
    xact(1'b0, 32'h10, 32'h0, 4'b0000, lat, rd, err);
    n_tests++; if (rd !== 32'hDEADABEF) begin n_fail++; $display("FAIL be0_keep: got %08h want DEADABEF", rd); end
  endtask

  task automatic test_reset_mid();
    int lat; logic [31:0] rd; logic err;
    xact(1'b1, 32'h20, 32'hCAFEF00D, BE_ALL, lat, rd, err);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 32'h20;
    req_wdata = 32'h12345678;
    req_be    = BE_ALL;
    cyc();
    req_valid = 1'b0;
    n_tests++; if (busy2 !== 1'b1) begin n_fail++; $display("FAIL mid_busy: got %b want 1", busy2); end
    cyc();
    n_tests++; if (rsp_valid2 !== 1'b1) begin n_fail++; $display("FAIL mid_resp: got %b want 1", rsp_valid2); end
    reset = 1'b0;
    cyc();
    n_tests++; if (rsp_valid2 !== 1'b0) begin n_fail++; $display("FAIL mid_rst_valid: got %b want 0", rsp_valid2); end
    n_tests++; if (req_ready2 !== 1'b0) begin n_fail++; $display("FAIL mid_rst_ready: got %b want 0", req_ready2); end
    reset = 1'b1;
    #1;
    n_tests++; if (req_ready2 !== 1'b1) begin n_fail++; $display("FAIL mid_ready_after: got %b want 1", req_ready2); end
    for (int i = 0; i < 3; i++) begin
      cyc();
      n_tests++; if (rsp_valid2 !== 1'b0) begin n_fail++; $display("FAIL mid_no_rsp[%0d]: got %b want 0", i, rsp_valid2); end
    end
    xact(1'b0, 32'h20, 32'h0, 4'b0000, lat, rd, err);
    n_tests++; if (rd !== 32'hCAFEF00D) begin n_fail++; $display("FAIL mid_keep: got %08h want CAFEF00D", rd); end
  endtask

  task automatic test_back_to_back_lat1();
    logic exp;
    apply_reset();
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 32'h10;
    req_be    = 4'b0000;
    for (int k = 1; k <= 10; k++) begin
      cyc();
      exp = (k % 2) == 1;
      if (rsp_valid1) $display("[TB] LAT1 cycle=%0d rsp_valid err=%0b", k, rsp_err1);
      n_tests++; if (rsp_valid1 !== exp) begin n_fail++; $display("FAIL b2b_valid[%0d]: got %b want %b", k, rsp_valid1, exp); end
      n_tests++; if (busy1 !== exp) begin n_fail++; $display("FAIL b2b_busy[%0d]: got %b want %b", k, busy1, exp); end
      n_tests++; if (req_ready1 !== !exp) begin n_fail++; $display("FAIL b2b_ready[%0d]: got %b want %b", k, req_ready1, !exp); end
    end
    req_valid = 1'b0;
    cyc();
  endtask

`ifdef DMEM_BUSY_CNT_EN
  task automatic test_busy_cnt();
    int guard;
    apply_reset();
    n_tests++; if (busy_cnt3 !== 32'd0) begin n_fail++; $display("FAIL bcnt_init: got %0d want 0", busy_cnt3); end
    req_write = 1'b0;
    req_addr  = 32'h10;
    req_be    = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      req_valid = 1'b1;
      cyc();
      req_valid = 1'b0;
      guard = 0;
      while (!rsp_valid3 && guard < 20) begin
        cyc();
        guard++;
      end
      $display("[TB] LAT3 load %0d waited=%0d", i, guard);
      cyc();
    end
    n_tests++; if (busy_cnt3 !== 32'd9) begin n_fail++; $display("FAIL bcnt3: got %0d want 9", busy_cnt3); end
    n_tests++; if (busy_cnt2 !== 32'd6) begin n_fail++; $display("FAIL bcnt2: got %0d want 6", busy_cnt2); end
    n_tests++; if (busy_cnt1 !== 32'd3) begin n_fail++; $display("FAIL bcnt1: got %0d want 3", busy_cnt1); end
    apply_reset();
    n_tests++; if (busy_cnt3 !== 32'd0) begin n_fail++; $display("FAIL bcnt_rst: got %0d want 0", busy_cnt3); end
  endtask
`endif

  initial begin
    test_reset();
    test_store_load();
    test_partial_store();
    test_faults();
    test_reset_mid();
    test_back_to_back_lat1();
`ifdef DMEM_BUSY_CNT_EN
    test_busy_cnt();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
